// File: rtl/epidemic_monitor_if.sv
// Record stream channel between epidemic_monitor and its consumer.
//   valid : record available (monitor -> consumer)
//   ready : consumer accepts the record (consumer -> monitor)
//   data  : {step, infected_count}
// master = record producer (epidemic_monitor), slave = record consumer.
interface epidemic_monitor_if #(
  parameter int W = 12
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/epidemic_monitor.sv
// epidemic_monitor: run controller and observer for the agent network.
// Loads a seed pattern into the network, samples its state vector once per
// generation, and streams {step, infected_count} records through a small FIFO.
// A run ends on a fixed point (steady) or after MAX_STEPS generations.
// Ports:
//   clk, rst        clock / asynchronous active-high reset
//   start, seed     launch pulse (honoured in IDLE) and seed pattern
//   net_init_state  seed pattern to the network, held for the run
//   net_load_state  one-cycle load strobe to the network
//   net_states      network state vector, one generation per RUN cycle
//   rec             record stream (master side), data = {step, count}
//   busy, done      run in progress / one-cycle end-of-run pulse
//   steady          sticky: last run ended on a fixed point
//   overflow        sticky: a record was dropped because the FIFO was full
module epidemic_monitor #(
  parameter int N          = 10,
  parameter int STEP_W     = 8,
  parameter int MAX_STEPS  = 200,
  parameter int FIFO_DEPTH = 16,
  localparam int CNT_W     = $clog2(N+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N-1:0]         seed,
  output logic [N-1:0]         net_init_state,
  output logic                 net_load_state,
  input  logic [N-1:0]         net_states,
  epidemic_monitor_if.master   rec,
  output logic                 busy,
  output logic                 done,
  output logic                 steady,
  output logic                 overflow
);
  localparam int REC_W = STEP_W + CNT_W;
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t            state;
  logic [STEP_W-1:0] step;
  logic [N-1:0]      prev_states;
  logic [N-1:0]      seed_q;
  logic [CNT_W-1:0]  cnt;

  // record FIFO; pointers carry one extra bit to tell full from empty
  logic [REC_W-1:0]  mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              empty, full, pop, push, push_ok;

  logic              match, last;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) cnt = cnt + CNT_W'(net_states[i]);
  end

  assign match   = (step != '0) && (net_states == prev_states);
  assign last    = (step == STEP_W'(MAX_STEPS-1));

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = rec.valid && rec.ready;
  assign push    = (state == RUN);
  // a pop in the same cycle frees the slot the push needs
  assign push_ok = push && (!full || pop);

  assign rec.valid      = !empty;
  assign rec.data       = mem[rd_ptr[AW-1:0]];
  assign net_init_state = seed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= {step, cnt};
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      step           <= '0;
      prev_states    <= '0;
      seed_q         <= '0;
      net_load_state <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      steady         <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          seed_q         <= seed;
          net_load_state <= 1'b1;
          busy           <= 1'b1;
          steady         <= 1'b0;
          overflow       <= 1'b0;
          state          <= LOAD;
        end
        LOAD: begin
          net_load_state <= 1'b0;
          step           <= '0;
          state          <= RUN;
        end
        RUN: begin
          prev_states <= net_states;
          if (full && !pop) overflow <= 1'b1;
          if (match || last) begin
            if (match) steady <= 1'b1;
            state <= DRAIN;
          end else begin
            step <= step + 1'b1;
          end
        end
        DRAIN: if (empty) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_epidemic_monitor.sv
module tb_epidemic_monitor;
  localparam int N = 10, STEP_W = 8, MAXS = 8, DEPTH = 4, CNT_W = 4, RW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  seed = '0;
  logic [N-1:0]  net_states = '0;
  logic [N-1:0]  net_init_state;
  logic          net_load_state, busy, done, steady, overflow;

  epidemic_monitor_if #(.W(RW)) rec_if ();

  epidemic_monitor #(.N(N), .STEP_W(STEP_W), .MAX_STEPS(MAXS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .net_init_state(net_init_state), .net_load_state(net_load_state),
    .net_states(net_states), .rec(rec_if.master),
    .busy(busy), .done(done), .steady(steady), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // stimulus knobs: per-generation network states and ready behaviour
  logic [N-1:0] pat [8];
  int           rmode = 0;  // 0: ready=1, 1: ready=0, 2: random

  // behavioural model: phase 0 idle, 1 load, 2 run, 3 drain
  int             m_phase, m_step;
  logic [N-1:0]   m_prev, m_init;
  bit             m_load, m_busy, m_done, m_steady, m_ovf;
  logic [RW-1:0]  m_q[$];
  logic [RW-1:0]  rlog[$];   // every record the consumer accepted, in order

  always @(posedge clk or posedge rst) begin : model
    bit pop, push, was_empty, hit;
    logic [RW-1:0] r;
    if (rst) begin
      m_phase = 0; m_step = 0; m_prev = '0; m_init = '0;
      m_load = 0; m_busy = 0; m_done = 0; m_steady = 0; m_ovf = 0;
      m_q.delete();
    end else begin
      was_empty = (m_q.size() == 0);
      pop  = !was_empty && rec_if.ready;
      push = 0;
      m_done = 0;
      r = '0;
      case (m_phase)
        0: if (start) begin
          m_init = seed; m_load = 1; m_busy = 1; m_steady = 0; m_ovf = 0; m_phase = 1;
        end
        1: begin m_load = 0; m_step = 0; m_phase = 2; end
        2: begin
          push = 1;
          r = {STEP_W'(m_step), CNT_W'($countones(net_states))};
          hit = (m_step > 0) && (net_states == m_prev);
          m_prev = net_states;
          if (hit) m_steady = 1;
          if (hit || m_step == MAXS-1) m_phase = 3;
          else m_step++;
        end
        default: if (was_empty) begin m_phase = 0; m_busy = 0; m_done = 1; end
      endcase
      if (pop) begin rlog.push_back(m_q[0]); void'(m_q.pop_front()); end
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(r);
        else m_ovf = 1;
      end
    end
  end

  // input driver, away from the active edge
  always @(negedge clk) begin
    net_states = pat[m_step % 8];
    case (rmode)
      0:       rec_if.ready = 1'b1;
      1:       rec_if.ready = 1'b0;
      default: rec_if.ready = 1'($urandom_range(0, 1));
    endcase
  end

  // per-cycle comparison against the model
  int load_cnt = 0;
  always @(negedge clk) begin
    if (net_load_state) load_cnt++;
    chk("rec_valid", rec_if.valid, m_q.size() != 0);
    if (m_q.size() != 0) chk("rec_data", rec_if.data, m_q[0]);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("steady", steady, m_steady);
    chk("overflow", overflow, m_ovf);
    chk("load", net_load_state, m_load);
    chk("init", net_init_state, m_init);
  end

  task automatic start_run(input logic [N-1:0] s);
    @(negedge clk); start = 1'b1; seed = s;
    @(negedge clk); start = 1'b0; seed = N'($urandom);
    #1;
    chk("load_strobe", net_load_state, 1);
    chk("load_seed", net_init_state, s);
  endtask

  task automatic wait_done(input int lim);
    bit seen = 0;
    for (int k = 0; k < lim && !seen; k++) begin
      @(negedge clk); #1;
      if (done) seen = 1;
    end
    chk("done_seen", seen, 1);
  endtask

  task automatic wait_phase(input int ph, input int st, input int lim);
    bit seen = 0;
    for (int k = 0; k < lim && !seen; k++) begin
      @(negedge clk); #1;
      if (m_phase == ph && (st < 0 || m_step == st)) seen = 1;
    end
    chk("phase_reached", seen, 1);
  endtask

  task automatic set_pat(input logic [N-1:0] p0, p1, p2, p3, p4, p5, p6, p7);
    pat[0] = p0; pat[1] = p1; pat[2] = p2; pat[3] = p3;
    pat[4] = p4; pat[5] = p5; pat[6] = p6; pat[7] = p7;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int base, ld0;
    logic [RW-1:0] exp2 [4];
    logic [CNT_W-1:0] exp3 [8];
    exp2 = '{12'h001, 12'h012, 12'h023, 12'h033};
    exp3 = '{4'd1, 4'd1, 4'd2, 4'd1, 4'd2, 4'd2, 4'd3, 4'd1};
    set_pat(0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", rec_if.valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load", net_load_state, 0);
    chk("rst_init", net_init_state, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // load strobe + steady detection
    set_pat(10'h001, 10'h003, 10'h007, 10'h007, 10'h00F, 10'h01F, 10'h03F, 10'h07F);
    rmode = 0; base = rlog.size(); ld0 = load_cnt;
    start_run(10'h001);
    wait_done(100);
    chk("t2_nrec", rlog.size() - base, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_rec%0d", i), rlog[base+i], exp2[i]);
    chk("t2_steady", steady, 1);
    chk("t2_loads", load_cnt - ld0, 1);
    repeat (3) @(negedge clk);
    #1 chk("t2_no5th", rec_if.valid, 0);

    // forced stop; steady from the previous run must clear on start
    set_pat(10'h001, 10'h002, 10'h003, 10'h004, 10'h005, 10'h006, 10'h007, 10'h008);
    base = rlog.size();
    start_run(10'h0F0);
    chk("t3_steady_clr", steady, 0);
    wait_done(100);
    chk("t3_nrec", rlog.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_step%0d", i), rlog[base+i][RW-1:CNT_W], i);
      chk($sformatf("t3_cnt%0d", i), rlog[base+i][CNT_W-1:0], exp3[i]);
    end
    chk("t3_steady", steady, 0);

    // backpressure: only the first DEPTH records survive
    rmode = 1; base = rlog.size();
    start_run(10'h00F);
    wait_phase(3, -1, 50);
    rmode = 0;
    wait_done(100);
    chk("t4_nrec", rlog.size() - base, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t4_step%0d", i), rlog[base+i][RW-1:CNT_W], i);
    chk("t4_ovf", overflow, 1);

    // abort mid-run, then restart; overflow clears on start
    start_run(10'h155);
    chk("t5_ovf_clr", overflow, 0);
    wait_phase(2, 3, 50);
    rst = 1'b1;
    #1;
    chk("t5_valid", rec_if.valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_init", net_init_state, 0);
    chk("t5_steady", steady, 0);
    @(negedge clk); #1;
    chk("t5_done", done, 0);
    rst = 1'b0;
    set_pat(10'h000, 10'h3FF, 10'h000, 10'h3FF, 10'h3FF, 10'h000, 10'h000, 10'h000);
    base = rlog.size();
    start_run(10'h3FF);
    wait_done(100);
    chk("t5_nrec", rlog.size() - base, 5);
    chk("t5_zero", rlog[base+0], 12'h000);
    chk("t5_full", rlog[base+1], 12'h01A);
    chk("t5_last", rlog[base+4], 12'h04A);
    chk("t5_steady_end", steady, 1);

    // start while busy is ignored
    set_pat(10'h001, 10'h002, 10'h003, 10'h004, 10'h005, 10'h006, 10'h007, 10'h008);
    ld0 = load_cnt;
    start_run(10'h2AA);
    wait_phase(2, 2, 50);
    start = 1'b1; seed = 10'h3FF;
    @(negedge clk); start = 1'b0;
    wait_done(100);
    chk("t6_init", net_init_state, 10'h2AA);
    chk("t6_loads", load_cnt - ld0, 1);

    // randomized runs
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 8; i++)
        pat[i] = (i > 0 && $urandom_range(0, 3) == 0) ? pat[i-1] : N'($urandom);
      rmode = $urandom_range(0, 2);
      start_run(N'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        start = 1'b1; seed = N'($urandom);
        @(negedge clk); start = 1'b0;
      end
      if (rmode == 1) begin
        wait_phase(3, -1, 50);
        rmode = 2;
      end
      wait_done(400);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
